// File: rtl/pmod_serial_tx_if.sv
// Producer-to-transmitter bundle for the PMOD serial transmitter.
// The producer drives the word and valid and observes the line status.
interface pmod_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_Tx_Data;
  logic              i_Tx_Valid;
  logic              o_Tx_Ready;
  logic              o_PMOD_Data;
  logic              o_Tx_Busy;
  logic              o_Tx_Done;

  modport master (
    output i_Tx_Data, i_Tx_Valid,
    input  o_Tx_Ready, o_PMOD_Data, o_Tx_Busy, o_Tx_Done
  );

  modport slave (
    input  i_Tx_Data, i_Tx_Valid,
    output o_Tx_Ready, o_PMOD_Data, o_Tx_Busy, o_Tx_Done
  );
endinterface

// File: rtl/pmod_serial_tx.sv
// Serial frame transmitter for a single PMOD pin: start bit, DATA_W data
// bits LSB first, optional parity, 1 or 2 stop bits, idle-high line.
// A one-word hold register behind a valid/ready handshake lets the next
// frame start directly after the last stop bit.
module pmod_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  pmod_serial_tx_if.slave  bus
);

  localparam int   TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int   IDX_W = $clog2(DATA_W + 1);
  localparam logic ODD_L = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  generate
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
      $error("pmod_serial_tx: DATA_W must be 1..32");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
      $error("pmod_serial_tx: CLKS_PER_BIT must be >= 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("pmod_serial_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity of a loaded word: even parity is the XOR-reduce, odd inverts it.
  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (^w) ^ ODD_L;
  endfunction

  state_t              state_r, state_n;
  logic [TMR_W-1:0]    tmr_r, tmr_n;
  logic [IDX_W-1:0]    idx_r, idx_n;
  logic [DATA_W-1:0]   shift_r, shift_n;
  logic [DATA_W-1:0]   hold_r, hold_n;
  logic                hold_full_r, hold_full_n;
  logic                par_r, par_n;
  logic                ready_r, line_r, line_n, busy_r, done_r, done_n;
  logic                bit_end_s, last_data_s, last_stop_s, load_s, capture_s;

  assign bit_end_s   = (tmr_r == TMR_W'(CLKS_PER_BIT - 1));
  assign last_data_s = (idx_r == IDX_W'(DATA_W - 1));
  assign last_stop_s = (idx_r == IDX_W'(STOP_BITS - 1));
  assign capture_s   = bus.i_Tx_Valid & ready_r;

  // Next-state logic: advance one state per completed bit period group.
  always_comb begin
    state_n = state_r;
    load_s  = 1'b0;
    done_n  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (hold_full_r) begin
          state_n = S_START;
          load_s  = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) state_n = S_DATA;
        else           state_n = S_START;
      end
      S_DATA: begin
        if (bit_end_s && last_data_s) state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        else                          state_n = S_DATA;
      end
      S_PARITY: begin
        if (bit_end_s) state_n = S_STOP;
        else           state_n = S_PARITY;
      end
      S_STOP: begin
        if (bit_end_s && last_stop_s) begin
          done_n = 1'b1;
          if (hold_full_r) begin
            state_n = S_START;
            load_s  = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          state_n = S_STOP;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath next values: timer, bit index, shifter, hold buffer and line.
  always_comb begin
    if (state_r == S_IDLE || bit_end_s) tmr_n = '0;
    else                                tmr_n = tmr_r + TMR_W'(1);

    if (state_n != state_r)                     idx_n = '0;
    else if (bit_end_s && state_r != S_IDLE)    idx_n = idx_r + IDX_W'(1);
    else                                        idx_n = idx_r;

    if (load_s)                             shift_n = hold_r;
    else if (state_r == S_DATA && bit_end_s) shift_n = shift_r >> 1;
    else                                    shift_n = shift_r;

    if (load_s) par_n = parity_of(hold_r);
    else        par_n = par_r;

    if (capture_s) hold_n = bus.i_Tx_Data;
    else           hold_n = hold_r;

    if (capture_s)   hold_full_n = 1'b1;
    else if (load_s) hold_full_n = 1'b0;
    else             hold_full_n = hold_full_r;

    case (state_n)
      S_START:  line_n = 1'b0;
      S_DATA:   line_n = shift_n[0];
      S_PARITY: line_n = par_n;
      default:  line_n = 1'b1;
    endcase
  end

  // State and datapath registers; the line goes high at once on reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r     <= S_IDLE;
      tmr_r       <= '0;
      idx_r       <= '0;
      shift_r     <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      par_r       <= 1'b0;
      ready_r     <= 1'b1;
      line_r      <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      tmr_r       <= tmr_n;
      idx_r       <= idx_n;
      shift_r     <= shift_n;
      hold_r      <= hold_n;
      hold_full_r <= hold_full_n;
      par_r       <= par_n;
      ready_r     <= ~hold_full_n;
      line_r      <= line_n;
      busy_r      <= (state_n != S_IDLE);
      done_r      <= done_n;
    end
  end

  assign bus.o_Tx_Ready  = ready_r;
  assign bus.o_PMOD_Data = line_r;
  assign bus.o_Tx_Busy   = busy_r;
  assign bus.o_Tx_Done   = done_r;

endmodule

// File: tb/tb_pmod_serial_tx.sv
// Bench for pmod_serial_tx: five configurations, each driven with directed
// and random words and compared cycle by cycle against a queue-based model
// of the expected line waveform, hold buffer and Done pulses.
module tb_pmod_serial_tx;

  localparam int NI = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   data_v [NI];
  logic [NI-1:0] valid_v;
  logic [NI-1:0] line_s, busy_s, ready_s, done_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pmod_serial_tx_if #(.DATA_W(8))  if0 ();
  pmod_serial_tx_if #(.DATA_W(8))  if1 ();
  pmod_serial_tx_if #(.DATA_W(8))  if2 ();
  pmod_serial_tx_if #(.DATA_W(8))  if3 ();
  pmod_serial_tx_if #(.DATA_W(12)) if4 ();

  pmod_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u0 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if0));
  pmod_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u1 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if1));
  pmod_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u2 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if2));
  pmod_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u3 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if3));
  pmod_serial_tx #(.DATA_W(12), .CLKS_PER_BIT(3), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u4 (.i_Clk(clk), .i_Rst_L(rst_n), .bus(if4));

  assign if0.i_Tx_Data = data_v[0][7:0];
  assign if1.i_Tx_Data = data_v[1][7:0];
  assign if2.i_Tx_Data = data_v[2][7:0];
  assign if3.i_Tx_Data = data_v[3][7:0];
  assign if4.i_Tx_Data = data_v[4][11:0];
  assign if0.i_Tx_Valid = valid_v[0];
  assign if1.i_Tx_Valid = valid_v[1];
  assign if2.i_Tx_Valid = valid_v[2];
  assign if3.i_Tx_Valid = valid_v[3];
  assign if4.i_Tx_Valid = valid_v[4];
  assign line_s  = {if4.o_PMOD_Data, if3.o_PMOD_Data, if2.o_PMOD_Data, if1.o_PMOD_Data, if0.o_PMOD_Data};
  assign busy_s  = {if4.o_Tx_Busy,   if3.o_Tx_Busy,   if2.o_Tx_Busy,   if1.o_Tx_Busy,   if0.o_Tx_Busy};
  assign ready_s = {if4.o_Tx_Ready,  if3.o_Tx_Ready,  if2.o_Tx_Ready,  if1.o_Tx_Ready,  if0.o_Tx_Ready};
  assign done_s  = {if4.o_Tx_Done,   if3.o_Tx_Done,   if2.o_Tx_Done,   if1.o_Tx_Done,   if0.o_Tx_Done};

  // Configuration of each instance, as the model sees it.
  function automatic int p_dw(input int k);   return (k == 4) ? 12 : 8; endfunction
  function automatic int p_cpb(input int k);  return (k == 3) ? 1 : ((k == 4) ? 3 : 2); endfunction
  function automatic int p_pen(input int k);  return (k == 1 || k == 2) ? 1 : 0; endfunction
  function automatic int p_podd(input int k); return (k == 2) ? 1 : 0; endfunction
  function automatic int p_stop(input int k); return (k == 4) ? 2 : 1; endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  bit          cur_q [$];   // expected line value for each upcoming cycle
  logic [31:0] words_q [$]; // words to offer in the next run
  bit          obs_q [$];   // observed line, one entry per cycle of the run
  int          done_list [$];
  int          obs_start;

  // Append the expected per-cycle line samples of one frame carrying w.
  task automatic push_frame(input int k, input logic [31:0] w);
    bit par;
    par = (p_podd(k) != 0);
    for (int i = 0; i < p_dw(k); i++) par = par ^ w[i];
    repeat (p_cpb(k)) cur_q.push_back(1'b0);
    for (int i = 0; i < p_dw(k); i++) repeat (p_cpb(k)) cur_q.push_back(w[i]);
    if (p_pen(k) != 0) repeat (p_cpb(k)) cur_q.push_back(par);
    repeat (p_cpb(k) * p_stop(k)) cur_q.push_back(1'b1);
  endtask

  // Offer words_q to instance k (valid held or random) and compare every cycle.
  task automatic run(input int k, input bit rand_valid, input int max_cyc);
    bit          hold_m = 1'b0;
    logic [31:0] hold_w = 32'd0;
    int          idx = 0;
    int          n = words_q.size();
    int          c = 0;
    bit          fin, hs, exp_line;
    cur_q.delete();
    obs_q.delete();
    done_list.delete();
    obs_start = -1;
    valid_v[k] = (n > 0) ? (rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
    data_v[k]  = (n > 0) ? words_q[0] : 32'd0;
    while (c < max_cyc && (idx < n || hold_m || cur_q.size() > 0)) begin
      @(posedge clk);
      hs  = valid_v[k] && !hold_m;
      fin = 1'b0;
      if (cur_q.size() > 0) begin
        void'(cur_q.pop_front());
        fin = (cur_q.size() == 0);
      end
      if (cur_q.size() == 0 && hold_m) begin
        push_frame(k, hold_w);
        hold_m = 1'b0;
      end
      if (hs) begin
        hold_m = 1'b1;
        hold_w = data_v[k];
        idx++;
      end
      #1;
      if (idx < n) begin
        valid_v[k] = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        data_v[k]  = words_q[idx];
      end else begin
        valid_v[k] = 1'b0;
        data_v[k]  = $urandom;
      end
      @(negedge clk);
      exp_line = (cur_q.size() > 0) ? cur_q[0] : 1'b1;
      check($sformatf("line[u%0d,c%0d]", k, c),  {31'd0, line_s[k]},  {31'd0, exp_line});
      check($sformatf("busy[u%0d,c%0d]", k, c),  {31'd0, busy_s[k]},  {31'd0, cur_q.size() > 0});
      check($sformatf("done[u%0d,c%0d]", k, c),  {31'd0, done_s[k]},  {31'd0, fin});
      check($sformatf("ready[u%0d,c%0d]", k, c), {31'd0, ready_s[k]}, {31'd0, !hold_m});
      obs_q.push_back(line_s[k]);
      if (obs_start < 0 && !line_s[k]) obs_start = c;
      if (done_s[k]) done_list.push_back(c);
      c++;
    end
    if (idx < n || hold_m || cur_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout u%0d got=%0d cycles exp=finish within %0d", k, c, max_cyc);
    end
    check($sformatf("done_count[u%0d]", k), done_list.size(), n);
  endtask

  initial begin
    logic [11:0] w12;
    logic [9:0]  pat;
    int          ones;
    int          base;
    bit          saw_done;

    rst_n   = 1'b0;
    valid_v = '0;
    for (int k = 0; k < NI; k++) data_v[k] = 32'd0;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_line[u%0d]", k),  {31'd0, line_s[k]},  32'd1);
      check($sformatf("rst_ready[u%0d]", k), {31'd0, ready_s[k]}, 32'd1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("post_rst_line[u%0d]", k),  {31'd0, line_s[k]},  32'd1);
      check($sformatf("post_rst_ready[u%0d]", k), {31'd0, ready_s[k]}, 32'd1);
      check($sformatf("post_rst_busy[u%0d]", k),  {31'd0, busy_s[k]},  32'd0);
      check($sformatf("post_rst_done[u%0d]", k),  {31'd0, done_s[k]},  32'd0);
    end

    // Default configuration, word 0x0C: explicit line pattern and latency.
    words_q = '{32'h0C};
    run(0, 1'b0, 200);
    pat = {1'b1, 8'h0C, 1'b0};
    check("start_latency_0c", obs_start, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("pat0c_a[%0d]", i), {31'd0, obs_q[obs_start + 2 * i]},     {31'd0, pat[i]});
      check($sformatf("pat0c_b[%0d]", i), {31'd0, obs_q[obs_start + 2 * i + 1]}, {31'd0, pat[i]});
    end
    check("done_after_start_0c", done_list[0] - obs_start, 20);

    // Parity bit for 0x07: even gives 1, odd gives 0.
    words_q = '{32'h07};
    run(1, 1'b0, 200);
    check("parity_even_07", {31'd0, obs_q[obs_start + 18]}, 32'd1);
    check("frame_len_even", done_list[0] - obs_start, 22);
    words_q = '{32'h07};
    run(2, 1'b0, 200);
    check("parity_odd_07", {31'd0, obs_q[obs_start + 18]}, 32'd0);

    // Back-to-back with one cycle per bit.
    words_q = '{32'hA5, 32'h3C};
    run(3, 1'b0, 200);
    check("b2b_done_gap", done_list[1] - done_list[0], 10);
    check("b2b_no_idle", {31'd0, obs_q[done_list[0]]}, 32'd0);

    // Backpressure: 16 incrementing words with valid held.
    base = $urandom_range(0, 255);
    words_q.delete();
    for (int i = 0; i < 16; i++) words_q.push_back((base + i) & 32'hFF);
    run(0, 1'b0, 1000);

    // Random words with random valid on every configuration.
    for (int k = 0; k < NI; k++) begin
      words_q.delete();
      for (int i = 0; i < 8; i++) words_q.push_back($urandom);
      run(k, 1'b1, 2000);
    end

    // Wide word, two stop bits, three cycles per bit.
    words_q = '{32'hABC};
    run(4, 1'b0, 300);
    w12 = 12'hABC;
    for (int i = 0; i < 12; i++)
      check($sformatf("w12_bit[%0d]", i), {31'd0, obs_q[obs_start + 3 * (1 + i) + 1]}, {31'd0, w12[i]});
    ones = 0;
    for (int i = 39; i < 45; i++) ones += obs_q[obs_start + i];
    check("w12_stop_high", ones, 6);
    check("w12_frame_len", done_list[0] - obs_start, 45);

    // Reset in the middle of the data bits of a 0x00 frame.
    valid_v[0] = 1'b1;
    data_v[0]  = 32'h00;
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("midrst_pre_line", {31'd0, line_s[0]}, 32'd0);
    check("midrst_pre_busy", {31'd0, busy_s[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_line_async", {31'd0, line_s[0]}, 32'd1);
    check("midrst_busy", {31'd0, busy_s[0]}, 32'd0);
    check("midrst_ready", {31'd0, ready_s[0]}, 32'd1);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_s[0]) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done_s[0]) saw_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, saw_done}, 32'd0);
    check("midrst_line_after", {31'd0, line_s[0]}, 32'd1);
    check("midrst_busy_after", {31'd0, busy_s[0]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
